// File: rtl/intersection_model.sv
// Closed-loop environment model for a two-direction traffic-light controller:
// turns light codes into queue-driven Ta/Tb sensors and flags unsafe or illegal light sequencing.
module intersection_model #(
    parameter int QW         = 4,
    parameter int DEPART_GAP = 2,
    parameter int SW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    input  logic          arrive_a,
    input  logic          arrive_b,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic [SW-1:0] served_a,
    output logic [SW-1:0] served_b,
    output logic [1:0]    ovf,
    output logic          err_conflict,
    output logic          err_seq
);

    // state     | meaning
    // CHK_WAIT  | first edge after reset release; light checks suppressed
    // CHK_ARMED | light checks active every cycle
    typedef enum logic {
        CHK_WAIT  = 1'b0,
        CHK_ARMED = 1'b1
    } chk_state_t;

    localparam logic [1:0]    L_GREEN  = 2'd0;
    localparam logic [1:0]    L_YELLOW = 2'd1;
    localparam logic [1:0]    L_RED    = 2'd2;
    localparam logic [1:0]    L_BAD    = 2'd3;
    localparam logic [QW-1:0] QMAX     = '1;
    localparam logic [3:0]    GAP_LAST = 4'(DEPART_GAP - 1);

    chk_state_t    state, state_next;
    logic          armed;
    logic [3:0]    gap_a, gap_b, gap_a_next, gap_b_next;
    logic [1:0]    prev_la, prev_lb;
    logic          dep_a, dep_b;
    logic [QW-1:0] qa_next, qb_next;
    logic [SW-1:0] served_a_next, served_b_next;
    logic          drop_a, drop_b;
    logic          conflict_hit, seq_hit;

    // Once the queue is empty at the last gap slot the counter parks there,
    // so a fresh arrival leaves on the very next green cycle.
    function automatic logic [3:0] gap_step(input logic [1:0] light,
                                            input logic [3:0] gap,
                                            input logic       dep);
        if (light != L_GREEN)
            return 4'd0;
        else if (gap < GAP_LAST)
            return gap + 4'd1;
        else if (dep)
            return 4'd0;
        else
            return gap;
    endfunction

    function automatic logic legal_step(input logic [1:0] from_l, input logic [1:0] to_l);
        case ({from_l, to_l})
            {L_GREEN,  L_GREEN},
            {L_GREEN,  L_YELLOW},
            {L_YELLOW, L_YELLOW},
            {L_YELLOW, L_RED},
            {L_RED,    L_RED},
            {L_RED,    L_GREEN}:  return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= CHK_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        armed      = 1'b0;
        case (state)
            CHK_WAIT:  state_next = CHK_ARMED;
            CHK_ARMED: armed = 1'b1;
            default:   state_next = CHK_WAIT;
        endcase
    end

    assign dep_a = (La == L_GREEN) && (gap_a == GAP_LAST) && (qa != '0);
    assign dep_b = (Lb == L_GREEN) && (gap_b == GAP_LAST) && (qb != '0);

    assign gap_a_next = gap_step(La, gap_a, dep_a);
    assign gap_b_next = gap_step(Lb, gap_b, dep_b);

    always_comb begin
        qa_next       = qa;
        served_a_next = served_a;
        drop_a        = 1'b0;
        if (dep_a) begin
            served_a_next = served_a + SW'(1);
            if (!arrive_a)
                qa_next = qa - QW'(1);
        end else if (arrive_a) begin
            if (qa == QMAX)
                drop_a = 1'b1;
            else
                qa_next = qa + QW'(1);
        end
    end

    always_comb begin
        qb_next       = qb;
        served_b_next = served_b;
        drop_b        = 1'b0;
        if (dep_b) begin
            served_b_next = served_b + SW'(1);
            if (!arrive_b)
                qb_next = qb - QW'(1);
        end else if (arrive_b) begin
            if (qb == QMAX)
                drop_b = 1'b1;
            else
                qb_next = qb + QW'(1);
        end
    end

    // Code 3 never satisfies legal_step, but it is called out separately for clarity.
    assign conflict_hit = armed && (La != L_RED) && (Lb != L_RED);
    assign seq_hit      = armed && ((La == L_BAD) || (Lb == L_BAD) ||
                                    !legal_step(prev_la, La) || !legal_step(prev_lb, Lb));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa           <= '0;
            qb           <= '0;
            served_a     <= '0;
            served_b     <= '0;
            gap_a        <= '0;
            gap_b        <= '0;
            ovf          <= '0;
            err_conflict <= 1'b0;
            err_seq      <= 1'b0;
            prev_la      <= L_RED;
            prev_lb      <= L_RED;
        end else begin
            qa           <= qa_next;
            qb           <= qb_next;
            served_a     <= served_a_next;
            served_b     <= served_b_next;
            gap_a        <= gap_a_next;
            gap_b        <= gap_b_next;
            ovf          <= ovf | {drop_b, drop_a};
            err_conflict <= err_conflict | conflict_hit;
            err_seq      <= err_seq | seq_hit;
            prev_la      <= La;
            prev_lb      <= Lb;
        end
    end

    assign Ta = (qa != '0);
    assign Tb = (qb != '0);

endmodule

// File: tb/tb_intersection_model.sv
// Randomized bench for intersection_model: two instances (DEPART_GAP 2 and 1) share stimulus
// and are compared every cycle against an arithmetic queue/light-rule model.
module tb_intersection_model;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] La, Lb;
    logic       arrive_a, arrive_b;

    logic       ta0, tb0, ta1, tb1;
    logic [3:0] qa0, qb0, qa1, qb1;
    logic [7:0] sa0, sb0, sa1, sb1;
    logic [1:0] ovf0, ovf1;
    logic       ec0, es0, ec1, es1;

    intersection_model #(.QW(4), .DEPART_GAP(2), .SW(8)) u0 (
        .clk(clk), .rst(rst), .La(La), .Lb(Lb), .arrive_a(arrive_a), .arrive_b(arrive_b),
        .Ta(ta0), .Tb(tb0), .qa(qa0), .qb(qb0), .served_a(sa0), .served_b(sb0),
        .ovf(ovf0), .err_conflict(ec0), .err_seq(es0)
    );

    intersection_model #(.QW(4), .DEPART_GAP(1), .SW(8)) u1 (
        .clk(clk), .rst(rst), .La(La), .Lb(Lb), .arrive_a(arrive_a), .arrive_b(arrive_b),
        .Ta(ta1), .Tb(tb1), .qa(qa1), .qb(qb1), .served_a(sa1), .served_b(sb1),
        .ovf(ovf1), .err_conflict(ec1), .err_seq(es1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state, indexed [instance][direction]; direction 0 is NS, 1 is EW.
    int dg[2];
    int m_q[2][2], m_gap[2][2], m_srv[2][2], m_ovf[2][2];
    int m_conf, m_seq, m_armed, m_pa, m_pb;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Light cycle is G(0) -> Y(1) -> R(2) -> G, with dwelling allowed.
    function automatic bit legal(input int p, input int c);
        return (p != 3) && (c != 3) && ((c == p) || (c == (p + 1) % 3));
    endfunction

    function automatic logic rb(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int d = 0; d < 2; d++) begin
                m_q[i][d] = 0; m_gap[i][d] = 0; m_srv[i][d] = 0; m_ovf[i][d] = 0;
            end
        m_conf = 0; m_seq = 0; m_armed = 0; m_pa = 2; m_pb = 2;
    endtask

    task automatic model_step();
        int  l;
        int  arr;
        bit  dep;
        for (int i = 0; i < 2; i++)
            for (int d = 0; d < 2; d++) begin
                l   = (d == 0) ? int'(La) : int'(Lb);
                arr = (d == 0) ? int'(arrive_a) : int'(arrive_b);
                dep = (l == 0) && (m_gap[i][d] == dg[i] - 1) && (m_q[i][d] > 0);
                if (l != 0)                      m_gap[i][d] = 0;
                else if (m_gap[i][d] < dg[i] - 1) m_gap[i][d] = m_gap[i][d] + 1;
                else if (dep)                    m_gap[i][d] = 0;
                if (dep) begin
                    m_srv[i][d] = (m_srv[i][d] + 1) % 256;
                    if (arr == 0) m_q[i][d] = m_q[i][d] - 1;
                end else if (arr != 0) begin
                    if (m_q[i][d] == 15) m_ovf[i][d] = 1;
                    else                 m_q[i][d] = m_q[i][d] + 1;
                end
            end
        if (m_armed != 0) begin
            if (La != 2 && Lb != 2) m_conf = 1;
            if (!legal(m_pa, int'(La)) || !legal(m_pb, int'(Lb))) m_seq = 1;
        end
        m_armed = 1;
        m_pa = int'(La);
        m_pb = int'(Lb);
    endtask

    task automatic check_dut(input string n, input int i,
                             input logic ta, input logic tb,
                             input logic [3:0] qa, input logic [3:0] qb,
                             input logic [7:0] sa, input logic [7:0] sb,
                             input logic [1:0] ov, input logic ec, input logic es);
        check_eq({n, ".Ta"}, ta, int'(m_q[i][0] != 0));
        check_eq({n, ".Tb"}, tb, int'(m_q[i][1] != 0));
        check_eq({n, ".qa"}, qa, m_q[i][0]);
        check_eq({n, ".qb"}, qb, m_q[i][1]);
        check_eq({n, ".served_a"}, sa, m_srv[i][0]);
        check_eq({n, ".served_b"}, sb, m_srv[i][1]);
        check_eq({n, ".ovf"}, ov, m_ovf[i][1] * 2 + m_ovf[i][0]);
        check_eq({n, ".err_conflict"}, ec, m_conf);
        check_eq({n, ".err_seq"}, es, m_seq);
    endtask

    task automatic check_all();
        check_dut("u0", 0, ta0, tb0, qa0, qb0, sa0, sb0, ovf0, ec0, es0);
        check_dut("u1", 1, ta1, tb1, qa1, qb1, sa1, sb1, ovf1, ec1, es1);
    endtask

    // Called at a falling edge: drive, advance the model over the next rising edge, then compare.
    task automatic step(input logic [1:0] la, input logic [1:0] lb, input logic aa, input logic ab);
        La = la; Lb = lb; arrive_a = aa; arrive_b = ab;
        if (rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        La = 2'd2; Lb = 2'd2; arrive_a = 1'b0; arrive_b = 1'b0;
    endtask

    task automatic run_legal(input int rounds, input int pct);
        for (int r = 0; r < rounds; r++) begin
            repeat ($urandom_range(1, 8)) step(2'd0, 2'd2, rb(pct), rb(pct));
            repeat ($urandom_range(1, 3)) step(2'd1, 2'd2, rb(pct), rb(pct));
            step(2'd2, 2'd2, rb(pct), rb(pct));
            repeat ($urandom_range(1, 8)) step(2'd2, 2'd0, rb(pct), rb(pct));
            repeat ($urandom_range(1, 3)) step(2'd2, 2'd1, rb(pct), rb(pct));
            step(2'd2, 2'd2, rb(pct), rb(pct));
        end
    endtask

    initial begin
        dg[0] = 2;
        dg[1] = 1;
        rst = 1'b0;
        La = 2'd2; Lb = 2'd2; arrive_a = 1'b0; arrive_b = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;

        // Idle with EW green and no traffic.
        repeat (10) step(2'd2, 2'd0, 1'b0, 1'b0);
        check_eq("idle_qa", qa0, 0);
        check_eq("idle_err", {ec0, es0, ovf0}, 0);

        // Three NS arrivals at red, then a held green drains one every two cycles.
        do_reset();
        repeat (3) step(2'd2, 2'd2, 1'b1, 1'b0);
        step(2'd2, 2'd2, 1'b0, 1'b0);
        check_eq("drain_pre_ta", ta0, 1);
        check_eq("drain_pre_qa", qa0, 3);
        for (int k = 1; k <= 8; k++) begin
            step(2'd0, 2'd2, 1'b0, 1'b0);
            check_eq("drain_qa", qa0, (3 - k / 2) > 0 ? 3 - k / 2 : 0);
        end
        check_eq("drain_served", sa0, 3);
        check_eq("drain_ta_end", ta0, 0);

        // Saturation at QMAX with the 16th arrival dropped.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(2'd2, 2'd2, 1'b1, 1'b0);
            if (k == 15) check_eq("sat_ovf_before", ovf0, 0);
        end
        check_eq("sat_qa", qa0, 15);
        check_eq("sat_ovf", ovf0, 1);

        // DEPART_GAP=1 with arrivals every cycle: queue steady, served counts every cycle.
        do_reset();
        repeat (5) step(2'd2, 2'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(2'd0, 2'd2, 1'b1, 1'b0);
            check_eq("g1_qa", qa1, 5);
            check_eq("g1_served", sa1, k);
        end

        // Checks are suppressed on the arming edge.
        do_reset();
        step(2'd3, 2'd3, 1'b0, 1'b0);
        check_eq("arm_quiet", {ec0, es0}, 0);

        // One cycle of both green: conflict latches and stays.
        do_reset();
        repeat (3) step(2'd2, 2'd0, 1'b0, 1'b0);
        step(2'd0, 2'd0, 1'b0, 1'b0);
        check_eq("conf_set", ec0, 1);
        step(2'd1, 2'd0, 1'b0, 1'b0);
        repeat (21) step(2'd2, 2'd0, 1'b0, 1'b0);
        check_eq("conf_sticky", ec0, 1);
        check_eq("conf_seq_clear", es0, 0);

        // Illegal sequencing cases.
        do_reset();
        step(2'd2, 2'd2, 1'b0, 1'b0);
        step(2'd0, 2'd2, 1'b0, 1'b0);
        check_eq("seq_rg_ok", es0, 0);
        step(2'd2, 2'd2, 1'b0, 1'b0);
        check_eq("seq_gr", es0, 1);
        do_reset();
        step(2'd2, 2'd2, 1'b0, 1'b0);
        step(2'd1, 2'd2, 1'b0, 1'b0);
        check_eq("seq_ry", es0, 1);
        do_reset();
        step(2'd2, 2'd2, 1'b0, 1'b0);
        step(2'd3, 2'd2, 1'b0, 1'b0);
        check_eq("seq_code3", es0, 1);
        check_eq("seq_code3_conf", ec0, 0);
        do_reset();
        step(2'd2, 2'd2, 1'b0, 1'b0);
        repeat (10) begin
            step(2'd0, 2'd2, 1'b0, 1'b0);
            step(2'd1, 2'd2, 1'b0, 1'b0);
            step(2'd2, 2'd2, 1'b0, 1'b0);
        end
        check_eq("seq_cycle_ok", es0, 0);

        // Random legal traffic, light and heavy, with a reset landing mid-operation.
        do_reset();
        run_legal(40, 30);
        check_eq("rand_legal_err", {ec0, es0}, 0);
        do_reset();
        run_legal(40, 75);
        do_reset();
        run_legal(20, 50);

        // Random light codes including illegal ones.
        do_reset();
        repeat (400) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rb(50), rb(50));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
